// File: rtl/face_detect_pkg.sv
// Shared types for the face-detection cascade result path.
package face_detect_pkg;

  localparam int unsigned COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } face_result_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/face_result_fifo.sv
// Show-ahead result FIFO; head entry visible whenever non-empty, reads as zero when empty.
module face_result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop, is_full, is_empty;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign do_pop   = pop_i && !is_empty;
  // A pop in the same cycle frees the slot needed by a push into a full FIFO.
  assign do_push  = push_i && (!is_full || do_pop);

  assign valid_o = !is_empty;
  assign full_o  = is_full;
  assign data_o  = is_empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/face_candidate_collector.sv
// Gathers per-stage cascade verdicts for one window and queues accepted faces.
// Optional CASCADE_EARLY_REJECT_EN: finish a window on the first failing stage.
module face_candidate_collector
  import face_detect_pkg::*;
#(
  parameter int unsigned NUM_STAGE     = 10,
  parameter int unsigned DATA_WIDTH_12 = 12,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     i_window_valid,
  input  logic [DATA_WIDTH_12-1:0] i_window_x,
  input  logic [DATA_WIDTH_12-1:0] i_window_y,
  input  logic [NUM_STAGE-1:0]     i_stage_done,
  input  logic [NUM_STAGE-1:0]     i_candidate,
  input  logic                     i_face_ready,
  output logic                     o_busy,
  output logic                     o_window_done,
  output logic                     o_face_valid,
  output logic [DATA_WIDTH_12-1:0] o_face_x,
  output logic [DATA_WIDTH_12-1:0] o_face_y,
  output logic                     o_fifo_full,
  output logic [15:0]              o_drop_count
);

  localparam int unsigned ENTRY_W = 2 * DATA_WIDTH_12;

  fsm_state_e               state_q, state_d;
  logic [DATA_WIDTH_12-1:0] x_q, x_d, y_q, y_d;
  logic [NUM_STAGE-1:0]     done_q, done_d, pass_q, pass_d;
  logic                     window_done_q, window_done_d;
  logic [15:0]              drop_q, drop_d;

  logic                     face_c, pop_c, push_c;
  logic                     fifo_valid, fifo_full;
  logic [ENTRY_W-1:0]       fifo_head;

  assign face_c = (state_q == ST_DECIDE) && (&done_q) && (&pass_q);
  assign pop_c  = fifo_valid && i_face_ready;
  assign push_c = face_c;

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      done_q        <= '0;
      pass_q        <= '0;
      window_done_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      window_done_q <= window_done_d;
      drop_q        <= drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    done_d        = done_q;
    pass_d        = pass_q;
    window_done_d = 1'b0;
    drop_d        = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (i_window_valid) begin
          x_d     = i_window_x;
          y_d     = i_window_y;
          done_d  = '0;
          pass_d  = '0;
          state_d = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        // A repeated pulse for a finished stage replaces its earlier verdict.
        done_d = done_q | i_stage_done;
        pass_d = (pass_q & ~i_stage_done) | (i_candidate & i_stage_done);
`ifdef CASCADE_EARLY_REJECT_EN
        if ((|(i_stage_done & ~i_candidate)) || (&done_d)) state_d = ST_DECIDE;
`else
        if (&done_d) state_d = ST_DECIDE;
`endif
      end

      ST_DECIDE: begin
        window_done_d = 1'b1;
        state_d       = ST_IDLE;
        if (face_c && fifo_full && !pop_c && (drop_q != 16'hFFFF)) begin
          drop_d = drop_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  face_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_fpga),
    .rst_ni  (reset_fpga),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  ({x_q, y_q}),
    .data_o  (fifo_head),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  assign o_busy        = (state_q != ST_IDLE);
  assign o_window_done = window_done_q;
  assign o_face_valid  = fifo_valid;
  assign o_face_x      = fifo_head[ENTRY_W-1:DATA_WIDTH_12];
  assign o_face_y      = fifo_head[DATA_WIDTH_12-1:0];
  assign o_fifo_full   = fifo_full;
  assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_face_candidate_collector.sv
// Randomised bench for face_candidate_collector against a queue-based window model.
module tb_face_candidate_collector;

  localparam int NS = 10;
  localparam int W  = 12;
  localparam int D  = 8;

  logic          clk_fpga = 1'b0;
  logic          reset_fpga;
  logic          i_window_valid;
  logic [W-1:0]  i_window_x, i_window_y;
  logic [NS-1:0] i_stage_done, i_candidate;
  logic          i_face_ready;
  logic          o_busy, o_window_done, o_face_valid, o_fifo_full;
  logic [W-1:0]  o_face_x, o_face_y;
  logic [15:0]   o_drop_count;

  face_candidate_collector #(
    .NUM_STAGE     (NS),
    .DATA_WIDTH_12 (W),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk_fpga       (clk_fpga),
    .reset_fpga     (reset_fpga),
    .i_window_valid (i_window_valid),
    .i_window_x     (i_window_x),
    .i_window_y     (i_window_y),
    .i_stage_done   (i_stage_done),
    .i_candidate    (i_candidate),
    .i_face_ready   (i_face_ready),
    .o_busy         (o_busy),
    .o_window_done  (o_window_done),
    .o_face_valid   (o_face_valid),
    .o_face_x       (o_face_x),
    .o_face_y       (o_face_y),
    .o_fifo_full    (o_fifo_full),
    .o_drop_count   (o_drop_count)
  );

  always #5 clk_fpga = ~clk_fpga;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] mq [$];
  int unsigned    m_drops = 0;

  logic [NS-1:0] sd_tab   [0:63];
  logic [NS-1:0] cand_tab [0:63];
  int            sched_len;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic exp_wd, input logic exp_busy);
    logic [2*W-1:0] head;
    check_val("window_done", 32'(o_window_done), 32'(exp_wd));
    check_val("busy", 32'(o_busy), 32'(exp_busy));
    check_val("face_valid", 32'(o_face_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      head = mq[0];
      check_val("face_x", 32'(o_face_x), 32'(head[2*W-1:W]));
      check_val("face_y", 32'(o_face_y), 32'(head[W-1:0]));
    end
    check_val("fifo_full", 32'(o_fifo_full), 32'(mq.size() == D));
    check_val("drop_count", 32'(o_drop_count), m_drops);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_window_done", 32'(o_window_done), 32'd0);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_face_valid", 32'(o_face_valid), 32'd0);
    check_val("rst_face_x", 32'(o_face_x), 32'd0);
    check_val("rst_face_y", 32'(o_face_y), 32'd0);
    check_val("rst_fifo_full", 32'(o_fifo_full), 32'd0);
    check_val("rst_drop_count", 32'(o_drop_count), 32'd0);
  endtask

  function automatic logic pick_ready(input int pct, input bit at_decide);
    if (pct < 0) return at_decide;
    return ($urandom_range(0, 99) < pct);
  endfunction

  function automatic logic junk_wv();
    return ($urandom_range(0, 3) == 0);
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input logic wv, input logic [W-1:0] wx, input logic [W-1:0] wy,
                      input logic [NS-1:0] sd, input logic [NS-1:0] cand, input logic rdy,
                      input bit decide, input bit face, input logic [W-1:0] fx,
                      input logic [W-1:0] fy, input logic busy_after);
    bit popped;
    i_window_valid = wv;
    i_window_x     = wx;
    i_window_y     = wy;
    i_stage_done   = sd;
    i_candidate    = cand;
    i_face_ready   = rdy;
    @(posedge clk_fpga);
    popped = (mq.size() != 0) && rdy;
    if (popped) void'(mq.pop_front());
    if (decide && face) begin
      if (mq.size() < D) mq.push_back({fx, fy});
      else if (m_drops != 32'hFFFF) m_drops++;
    end
    @(negedge clk_fpga);
    check_outputs(decide, busy_after);
  endtask

  task automatic sched_clear(input int len);
    sched_len = len;
    for (int c = 0; c < 64; c++) begin
      sd_tab[c]   = '0;
      cand_tab[c] = NS'($urandom);
    end
  endtask

  task automatic sched_all_pass_fast();
    sched_clear(1);
    sd_tab[1]   = '1;
    cand_tab[1] = '1;
  endtask

  task automatic gen_random_sched();
    int len, t, t2;
    len = int'($urandom_range(1, 12));
    sched_clear(len);
    for (int k = 0; k < NS; k++) begin
      t = int'($urandom_range(1, len));
      sd_tab[t][k]   = 1'b1;
      cand_tab[t][k] = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 5) == 0) begin
        t2 = int'($urandom_range(1, len));
        if (!sd_tab[t2][k]) begin
          sd_tab[t2][k]   = 1'b1;
          cand_tab[t2][k] = ($urandom_range(0, 3) != 0);
        end
      end
    end
  endtask

  // Window model: verdict from the final per-stage flags, end cycle from the rules.
  task automatic run_window(input logic [W-1:0] wx, input logic [W-1:0] wy, input int ready_pct);
    logic [NS-1:0] done, pass;
    int  endc, gap;
    bit  face;
    done = '0;
    pass = '0;
    endc = sched_len;
    for (int c = 1; c <= sched_len; c++) begin
      done = done | sd_tab[c];
      pass = (pass & ~sd_tab[c]) | (cand_tab[c] & sd_tab[c]);
`ifdef CASCADE_EARLY_REJECT_EN
      if ((sd_tab[c] & ~cand_tab[c]) != '0) begin endc = c; break; end
`endif
      if (done == {NS{1'b1}}) begin endc = c; break; end
    end
    face = (done == {NS{1'b1}}) && (pass == {NS{1'b1}});

    step(1'b1, wx, wy, NS'($urandom), NS'($urandom), pick_ready(ready_pct, 0), 0, 0, 0, 0, 1'b1);
    for (int c = 1; c <= endc; c++) begin
      step(junk_wv(), W'($urandom), W'($urandom), sd_tab[c], cand_tab[c],
           pick_ready(ready_pct, 0), 0, 0, 0, 0, 1'b1);
    end
    step(junk_wv(), W'($urandom), W'($urandom), NS'($urandom), NS'($urandom),
         pick_ready(ready_pct, 1), 1, face, wx, wy, 1'b0);
    gap = int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++) begin
      step(1'b0, W'($urandom), W'($urandom), NS'($urandom), NS'($urandom),
           pick_ready(ready_pct, 0), 0, 0, 0, 0, 1'b0);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, '0, NS'($urandom), NS'($urandom), 1'b1, 0, 0, 0, 0, 1'b0);
    end
  endtask

  initial begin
    int pcts [4];
    pcts = '{0, 30, 70, 100};

    reset_fpga     = 1'b0;
    i_window_valid = 1'b0;
    i_window_x     = '0;
    i_window_y     = '0;
    i_stage_done   = '0;
    i_candidate    = '0;
    i_face_ready   = 1'b0;
    repeat (3) @(negedge clk_fpga);
    check_reset_outputs();
    reset_fpga = 1'b1;

    // Staggered all-pass window at (5,7).
    sched_clear(20);
    for (int k = 0; k < NS; k++) begin
      sd_tab[2*k+1][k]   = 1'b1;
      cand_tab[2*k+1][k] = 1'b1;
    end
    run_window(12'd5, 12'd7, 0);
    drain(3);

    // Stage 3 fails early at (1,1).
    sched_clear(14);
    sd_tab[2][3]   = 1'b1;
    cand_tab[2][3] = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (k != 3) begin
        sd_tab[3+k][k]   = 1'b1;
        cand_tab[3+k][k] = 1'b1;
      end
    end
    run_window(12'd1, 12'd1, 0);

    // Fill to full, overflow once, then push and pop together while full.
    for (int i = 0; i < D; i++) begin
      sched_all_pass_fast();
      run_window(W'(i + 1), W'(100 + i), 0);
    end
    sched_all_pass_fast();
    run_window(12'd50, 12'd50, 0);
    sched_all_pass_fast();
    run_window(12'd60, 12'd61, -1);
    drain(D + 2);

    // Reset in the middle of collection with four stages finished.
    step(1'b1, 12'd9, 12'd9, '0, '0, 1'b0, 0, 0, 0, 0, 1'b1);
    step(1'b0, '0, '0, NS'(4'hF), '1, 1'b0, 0, 0, 0, 0, 1'b1);
    reset_fpga = 1'b0;
    #1;
    mq.delete();
    m_drops = 0;
    check_reset_outputs();
    repeat (2) begin
      @(posedge clk_fpga);
      @(negedge clk_fpga);
      check_reset_outputs();
    end
    reset_fpga = 1'b1;
    sched_all_pass_fast();
    run_window(12'd2, 12'd3, 0);
    drain(2);

    for (int n = 0; n < 80; n++) begin
      gen_random_sched();
      run_window(W'($urandom), W'($urandom), pcts[$urandom_range(0, 3)]);
    end
    drain(D + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
